// File: rtl/vector_pkg.sv
// Shared types and default sizing for the vector outer-product block.
package vector_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N     = 2;

  typedef enum logic {
    MODE_OUTER = 1'b0,
    MODE_DIAG  = 1'b1
  } mode_e;

  // Off-diagonal lanes are forced to zero in diagonal mode.
  function automatic logic lane_cleared(input mode_e m, input int row, input int col);
    return (m == MODE_DIAG) && (row != col);
  endfunction

endpackage

// File: rtl/vop_mul_pipe.sv
// One WIDTH x WIDTH truncating multiplier followed by LATENCY enable-gated registers.
module vop_mul_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [LATENCY-1:0] stage_valid,
  input  logic               clear,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   y
);

  logic [WIDTH-1:0] product;

  assign product = a * b;

  // A stage only loads when a valid set enters it, so bubbles never disturb held data.
  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic [WIDTH-1:0] d_s;
    logic [WIDTH-1:0] q_r;

    if (k == 0) begin : g_first
      assign d_s = product;
    end else begin : g_next
      assign d_s = g_stage[k-1].q_r;
    end

    if (k == LATENCY - 1) begin : g_last
      always_ff @(posedge clk) begin
        if (rst) begin
          q_r <= '0;
        end else if (en && stage_valid[k]) begin
          q_r <= clear ? '0 : d_s;
        end else begin
          q_r <= q_r;
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (en && stage_valid[k]) begin
          q_r <= d_s;
        end else begin
          q_r <= q_r;
        end
      end
    end
  end

  assign y = g_stage[LATENCY-1].q_r;

endmodule

// File: rtl/vector_outer_product.sv
// Pipelined outer (or diagonal) product of two N-element vectors with valid/ready flow control.
module vector_outer_product
  import vector_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int N       = DEFAULT_N,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   a,
  input  logic [N*WIDTH-1:0]   b,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*N*WIDTH-1:0] result,
  output logic                 busy
);

  logic               en;
  logic [LATENCY-1:0] valid_r;
  logic [LATENCY-1:0] valid_in;
  mode_e              mode_r  [LATENCY];
  mode_e              mode_in [LATENCY];

  // Stage inputs: element k of the chain is what stage k captures on an enabled edge.
  always_comb begin
    en          = !valid_r[LATENCY-1] || out_ready;
    in_ready    = en && !rst;
    valid_in[0] = in_valid && !rst;
    mode_in[0]  = mode_e'(mode);
    for (int k = 1; k < LATENCY; k++) begin
      valid_in[k] = valid_r[k-1];
      mode_in[k]  = mode_r[k-1];
    end
  end

  // Valid/mode shift chain running beside the multiplier registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (en) begin
      for (int k = 0; k < LATENCY; k++) begin
        valid_r[k] <= valid_in[k];
        mode_r[k]  <= mode_in[k];
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_valid = valid_r[LATENCY-1];
  assign busy      = |valid_r;

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic clear_s;

      assign clear_s = lane_cleared(mode_in[LATENCY-1], i, j);

      vop_mul_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
      ) u_mul (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .stage_valid (valid_in),
        .clear       (clear_s),
        .a           (a[i*WIDTH +: WIDTH]),
        .b           (b[j*WIDTH +: WIDTH]),
        .y           (result[(i*N+j)*WIDTH +: WIDTH])
      );
    end
  end

endmodule

// File: tb/tb_vector_outer_product.sv
// Self-checking bench: directed table (N=2,W=32,L=2) plus randomized scoreboard run (N=4,W=16,L=3).
module tb_vector_outer_product;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, mode, out_valid, out_ready, busy;
  logic [63:0]  a, b;
  logic [127:0] result;

  logic         in_valid4, in_ready4, mode4, out_valid4, out_ready4, busy4;
  logic [63:0]  a4, b4;
  logic [255:0] result4;

  vector_outer_product #(.WIDTH(32), .N(2), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  vector_outer_product #(.WIDTH(16), .N(4), .LATENCY(3)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .mode(mode4), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .busy(busy4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0]  a;
    logic [63:0]  b;
    logic         mode;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[5];

  // Reference: each element is a plain modular product, zeroed off-diagonal in mode 1.
  function automatic logic [255:0] model4(input logic [63:0] av, input logic [63:0] bv, input logic m);
    logic [255:0] r;
    logic [31:0]  p;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        p = {16'd0, av[i*16 +: 16]} * {16'd0, bv[j*16 +: 16]};
        if (m && (i != j)) p = 32'd0;
        r[(i*4+j)*16 +: 16] = p[15:0];
      end
    end
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] held;
    logic         have_held, saw_stall;
    int           sent, got, seen;
    logic [255:0] exp_q[$];
    logic [255:0] held4;
    logic         stalled4;
    int           in_cnt, out_cnt;

    tbl[0] = '{a: {32'd4, 32'd3}, b: {32'd6, 32'd5}, mode: 1'b0,
               exp: {32'd24, 32'd20, 32'd18, 32'd15}};
    tbl[1] = '{a: {32'd5, 32'd6}, b: {32'd3, 32'd4}, mode: 1'b0,
               exp: {32'd15, 32'd20, 32'd18, 32'd24}};
    tbl[2] = '{a: {32'd2, 32'hFFFF_FFFF}, b: {32'd3, 32'd2}, mode: 1'b1,
               exp: {32'd6, 32'd0, 32'd0, 32'hFFFF_FFFE}};
    tbl[3] = '{a: {32'hFFFF_FFFF, 32'hFFFF_FFFF}, b: {32'd2, 32'hFFFF_FFFF}, mode: 1'b0,
               exp: {32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFE, 32'd1}};
    tbl[4] = '{a: {32'd9, 32'd7}, b: {32'd11, 32'd10}, mode: 1'b1,
               exp: {32'd99, 32'd0, 32'd0, 32'd70}};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; mode4 = 1'b0; out_ready4 = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, '0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);

    // Single sets: latency, value, and bubbles afterwards.
    for (int v = 0; v < 5; v++) begin
      in_valid = 1'b1; a = tbl[v].a; b = tbl[v].b; mode = tbl[v].mode;
      @(negedge clk);
      in_valid = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; mode = 1'($urandom);
      check($sformatf("lat_t1_v%0d", v), out_valid, 1'b0);
      @(negedge clk);
      check($sformatf("lat_t2_v%0d", v), out_valid, 1'b1);
      check($sformatf("value_v%0d", v), result, tbl[v].exp);
      @(negedge clk);
      check($sformatf("bubble_v%0d", v), out_valid, 1'b0);
      check($sformatf("bubble_hold_v%0d", v), result, tbl[v].exp);
    end

    // Back-to-back accepts produce consecutive outputs.
    in_valid = 1'b1; a = tbl[0].a; b = tbl[0].b; mode = tbl[0].mode;
    @(negedge clk);
    a = tbl[1].a; b = tbl[1].b; mode = tbl[1].mode;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_first_valid", out_valid, 1'b1);
    check("b2b_first", result, tbl[0].exp);
    @(negedge clk);
    check("b2b_second_valid", out_valid, 1'b1);
    check("b2b_second", result, tbl[1].exp);
    @(negedge clk);
    check("b2b_drained", out_valid, 1'b0);

    // Backpressure: 5 stalled cycles, three sets, all must emerge in order.
    sent = 0; got = 0; have_held = 1'b0; saw_stall = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (sent < 3);
      if (sent < 3) begin
        a = tbl[sent].a; b = tbl[sent].b; mode = tbl[sent].mode;
      end
      #1;
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && have_held) check("stall_hold", result, held);
      if (out_valid && !out_ready) begin
        held = result; have_held = 1'b1;
      end
      if (out_valid && out_ready) begin
        check($sformatf("stall_order_%0d", got), result, tbl[got].exp);
        got++;
        have_held = 1'b0;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall_in_ready_dropped", saw_stall, 1'b1);
    check("stall_count", got, 3);

    // Reset with two sets inside the pipe discards both.
    out_ready = 1'b0;
    in_valid = 1'b1; a = tbl[3].a; b = tbl[3].b; mode = tbl[3].mode;
    @(negedge clk);
    a = tbl[4].a; b = tbl[4].b; mode = tbl[4].mode;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1; in_valid = 1'b1;
    #1;
    check("rst_mid_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_result", result, '0);
    seen = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("post_rst_no_ghost", seen, 0);
    in_valid = 1'b1; a = tbl[2].a; b = tbl[2].b; mode = tbl[2].mode;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_first_valid", out_valid, 1'b1);
    check("post_rst_first", result, tbl[2].exp);

    // Randomized run on the 4x4 instance against the scoreboard.
    in_cnt = 0; out_cnt = 0; stalled4 = 1'b0; held4 = '0;
    for (int cyc = 0; cyc < 820; cyc++) begin
      @(negedge clk);
      if (cyc < 800) begin
        in_valid4  = ($urandom_range(0, 3) != 0);
        out_ready4 = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
      end
      a4 = {$urandom, $urandom}; b4 = {$urandom, $urandom}; mode4 = 1'($urandom);
      if (cyc % 97 == 5) begin
        a4[15:0] = 16'hFFFF; b4[15:0] = 16'hFFFF;
      end
      #1;
      if (stalled4) begin
        check("rand_hold_valid", out_valid4, 1'b1);
        check("rand_hold_result", result4, held4);
      end
      stalled4 = out_valid4 && !out_ready4;
      held4    = result4;
      if (out_valid4 && out_ready4) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rand_extra actual=%0h required=none", result4);
        end else begin
          check($sformatf("rand_out_%0d", out_cnt), result4, exp_q.pop_front());
        end
      end
      if (in_valid4 && in_ready4) begin
        exp_q.push_back(model4(a4, b4, mode4));
        in_cnt++;
      end
    end
    check("rand_count", out_cnt, in_cnt);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_busy_idle", busy4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_outer_product.md
VECTOR_OUTER_PRODUCT -- requirements
Module: vector_outer_product

Interface
REQ-001 Parameter: WIDTH, 32, element width in bits (>=2).
REQ-002 Parameter: N, 2, vector length (>=1).
REQ-003 Parameter: LATENCY, 2, pipeline depth from accept to result (>=1).
REQ-004 clk  input  1  one clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operand set a/b/mode presented.
REQ-007 in_ready  output  1  block can accept an operand set this cycle.
REQ-008 a  input  N*WIDTH  vector A; element i at bits [i*WIDTH +: WIDTH].
REQ-009 b  input  N*WIDTH  vector B; same packing as a.
REQ-010 mode  input  1  0 = full outer product, 1 = diagonal (elementwise) product.
REQ-011 out_valid  output  1  result holds a valid product matrix.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 result  output  N*N*WIDTH  element (i,j) at bits [(i*N+j)*WIDTH +: WIDTH].
REQ-014 busy  output  1  any operand set in flight or held at output.

Function
REQ-015 Accept occurs on a cycle with in_valid && in_ready; a, b, mode are sampled only then.
REQ-016 Mode 0: result(i,j) SHALL equal a[i]*b[j], unsigned, truncated to low WIDTH bits (modulo 2^WIDTH).
REQ-017 Mode 1: result(i,i) SHALL equal a[i]*b[i] truncated; all off-diagonal elements SHALL be 0.
REQ-018 Unstalled, an operand set accepted at cycle t SHALL appear with out_valid=1 at cycle t+LATENCY.
REQ-019 Pipeline advance enable = !out_valid || out_ready; in_ready SHALL equal this enable (combinational).
REQ-020 When enable=0 all pipeline stages, out_valid and result SHALL hold unchanged.
REQ-021 While out_valid && !out_ready, result SHALL remain stable until the transfer cycle.
REQ-022 Simultaneous accept and output transfer in one cycle SHALL be legal; sustained throughput 1 set/cycle.
REQ-023 Cycles with in_valid=0 while enabled SHALL insert bubbles (stage valid=0); bubbles never raise out_valid.
REQ-024 Results SHALL leave in acceptance order; no set dropped or duplicated under any backpressure pattern.
REQ-025 busy SHALL be 1 iff any stage valid bit or out_valid is 1.
REQ-026 Operand values on cycles without accept SHALL have no effect on any output.

Reset
REQ-027 rst=1 at a rising edge SHALL clear all stage valid bits and out_valid to 0, and result to 0.
REQ-028 During rst=1, in_ready SHALL be 0; no accept occurs in a reset cycle.
REQ-029 Reset mid-operation SHALL discard all in-flight and held sets; first accept after reset yields first output.
REQ-030 Data registers other than result need no reset; only valid bits must be reset.

Structure
REQ-031 Shared package vector_pkg SHALL hold the mode enum (MODE_OUTER=0, MODE_DIAG=1) and default WIDTH/N constants.
REQ-032 One sub-module vop_mul_pipe SHALL implement a single WIDTH x WIDTH truncating multiply with LATENCY registers and an enable input; instantiate N*N times via generate.
REQ-033 Valid bits and mode SHALL travel in a shift chain parallel to vop_mul_pipe, gated by the same enable.

Verification
REQ-034 N=2, W=32, L=2: accept a=(3,4), b=(5,6), mode 0, out_ready=1 -> 2 cycles later out_valid=1, result (15,18,20,24).
REQ-035 Back-to-back accepts a=(3,4)/b=(5,6) then a=(6,5)/b=(4,3) -> consecutive outputs (15,18,20,24) then (24,18,20,15).
REQ-036 a=(0xFFFFFFFF,2), b=(2,3), mode 1 -> result (0xFFFFFFFE,0,0,6).
REQ-037 out_ready=0 for 5 cycles with 3 sets issued -> in_ready drops, result held stable, all 3 emerge in order after release.
REQ-038 rst pulsed with 2 sets in flight -> out_valid=0, busy=0 next cycle; none of those sets ever appear.
REQ-039 Random operands, random in_valid/out_ready, N=4, W=16 -> every output matches scoreboard model, count equal.
